// File: rtl/register_write_arbiter_if.sv
// Bus between pipeline, scoreboard/arbiter and register file write port.
// Ports: ALU/load write handshakes, load issue, decode query, RF write.
interface register_write_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ready;
   logic          ld_valid;
   logic [AW-1:0] ld_rd;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          issue_ld;
   logic [AW-1:0] issue_ld_rd;
   logic [AW-1:0] q_rs1;
   logic [AW-1:0] q_rs2;
   logic [AW-1:0] q_rd;
   logic          hazard;
   logic [AW:0]   pending_count;
   logic [AW-1:0] rd;
   logic          rd_write_enable;
   logic [DW-1:0] rd_data_in;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      output issue_ld, issue_ld_rd,
      output q_rs1, q_rs2, q_rd,
      input  alu_ready, ld_ready, hazard,
      input  pending_count,
      input  rd, rd_write_enable, rd_data_in
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      input  issue_ld, issue_ld_rd,
      input  q_rs1, q_rs2, q_rd,
      output alu_ready, ld_ready, hazard,
      output pending_count,
      output rd, rd_write_enable, rd_data_in
   );
endinterface

// File: rtl/register_write_arbiter.sv
// Arbitrates the RF write port between ALU and load return, with a
// load scoreboard for decode hazards. Ports: clk, rst_n, bus (slave).
module register_write_arbiter #(
   parameter int AddressBitWidth = 5,
   parameter int DataBitWidth    = 32,
   parameter int StarveLimit     = 3
) (
   input logic                     clk,
   input logic                     rst_n,
   register_write_arbiter_if.slave bus
);
   localparam int NReg = 2 ** AddressBitWidth;
   localparam int CW =
      (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
   localparam logic [CW-1:0] Lim = CW'(StarveLimit);

   logic [NReg-1:0]            r_pending;
   logic [NReg-1:0]            w_pend_nxt;
   logic [CW-1:0]              r_wait_cnt;
   logic [CW-1:0]              w_wait_nxt;
   logic [AddressBitWidth:0]   r_count;
   logic [AddressBitWidth:0]   w_count_nxt;
   logic                       w_force;
   logic                       w_alu_gnt;
   logic                       w_ld_gnt;
   logic [AddressBitWidth-1:0] w_rd;
   logic [DataBitWidth-1:0]    w_data;

   // Starved load overrides ALU priority for one cycle.
   assign w_force   = bus.ld_valid && (r_wait_cnt == Lim);
   assign w_ld_gnt  = rst_n && bus.ld_valid &&
                      (!bus.alu_valid || w_force);
   assign w_alu_gnt = rst_n && bus.alu_valid && !w_force;

   assign bus.alu_ready = !w_force;
   assign bus.ld_ready  = w_ld_gnt;

   always_comb begin
      w_rd   = '0;
      w_data = '0;
      unique case (1'b1)
         w_ld_gnt: begin
            w_rd   = bus.ld_rd;
            w_data = bus.ld_data;
         end
         w_alu_gnt: begin
            w_rd   = bus.alu_rd;
            w_data = bus.alu_data;
         end
         default: begin
            w_rd   = '0;
            w_data = '0;
         end
      endcase
   end

   assign bus.rd              = w_rd;
   assign bus.rd_data_in      = w_data;
   assign bus.rd_write_enable =
      (w_ld_gnt || w_alu_gnt) && (w_rd != '0);

   always_comb begin
      w_wait_nxt = r_wait_cnt;
      if (!bus.ld_valid || w_ld_gnt)
         w_wait_nxt = '0;
      else if (r_wait_cnt != Lim)
         w_wait_nxt = r_wait_cnt + 1'b1;
   end

   // Set after clear so a same-cycle reissue keeps the bit.
   always_comb begin
      w_pend_nxt = r_pending;
      if (w_ld_gnt)
         w_pend_nxt[bus.ld_rd] = 1'b0;
      if (bus.issue_ld)
         w_pend_nxt[bus.issue_ld_rd] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_comb begin
      w_count_nxt = '0;
      for (int i = 0; i < NReg; i++)
         w_count_nxt = w_count_nxt +
            {{AddressBitWidth{1'b0}}, w_pend_nxt[i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending  <= '0;
         r_wait_cnt <= '0;
         r_count    <= '0;
      end else begin
         r_pending  <= w_pend_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_count    <= w_count_nxt;
      end
   end

   assign bus.pending_count = r_count;
   assign bus.hazard = r_pending[bus.q_rs1] |
                       r_pending[bus.q_rs2] |
                       r_pending[bus.q_rd];

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (w_ld_gnt && bus.ld_rd != '0 &&
          !r_pending[bus.ld_rd])
         $display("register_write_arbiter: warning, %s x%0d",
                  "load return without pending issue to",
                  bus.ld_rd);
   end
`endif
endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter.
// Ports: none; drives the arbiter through its interface.
module tb_register_write_arbiter;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   register_write_arbiter_if #(.AW(5), .DW(32)) bus ();

   register_write_arbiter #(
      .AddressBitWidth(5),
      .DataBitWidth(32),
      .StarveLimit(3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = '0;
      bus.alu_data    = '0;
      bus.ld_valid    = 1'b0;
      bus.ld_rd       = '0;
      bus.ld_data     = '0;
      bus.issue_ld    = 1'b0;
      bus.issue_ld_rd = '0;
      bus.q_rs1       = '0;
      bus.q_rs2       = '0;
      bus.q_rd        = '0;
   endtask

   task automatic chk_rst(input string p);
      chk({p, "_alu_rdy"}, 64'(bus.alu_ready), 64'd1);
      chk({p, "_ld_rdy"}, 64'(bus.ld_ready), 64'd0);
      chk({p, "_we"}, 64'(bus.rd_write_enable), 64'd0);
      chk({p, "_rd"}, 64'(bus.rd), 64'd0);
      chk({p, "_data"}, 64'(bus.rd_data_in), 64'd0);
      chk({p, "_haz"}, 64'(bus.hazard), 64'd0);
      chk({p, "_cnt"}, 64'(bus.pending_count), 64'd0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle();
      #12;
      chk_rst("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // plain ALU write
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd5;
      bus.alu_data  = 32'hDEADBEEF;
      #1;
      chk("alu_rd", 64'(bus.rd), 64'd5);
      chk("alu_we", 64'(bus.rd_write_enable), 64'd1);
      chk("alu_data", 64'(bus.rd_data_in), 64'hDEADBEEF);
      chk("alu_rdy", 64'(bus.alu_ready), 64'd1);
      chk("alu_ldrdy", 64'(bus.ld_ready), 64'd0);
      tick();

      // load issue, hazard, return
      idle();
      bus.issue_ld    = 1'b1;
      bus.issue_ld_rd = 5'd7;
      bus.q_rs1       = 5'd7;
      #1;
      chk("x7_haz_pre", 64'(bus.hazard), 64'd0);
      tick();
      bus.issue_ld = 1'b0;
      #1;
      chk("x7_haz", 64'(bus.hazard), 64'd1);
      chk("x7_cnt", 64'(bus.pending_count), 64'd1);
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd7;
      bus.ld_data  = 32'h1234;
      #1;
      chk("x7_ldrdy", 64'(bus.ld_ready), 64'd1);
      chk("x7_we", 64'(bus.rd_write_enable), 64'd1);
      chk("x7_rd", 64'(bus.rd), 64'd7);
      chk("x7_data", 64'(bus.rd_data_in), 64'h1234);
      chk("x7_haz_wr", 64'(bus.hazard), 64'd1);
      tick();
      bus.ld_valid = 1'b0;
      #1;
      chk("x7_haz_clr", 64'(bus.hazard), 64'd0);
      chk("x7_cnt_clr", 64'(bus.pending_count), 64'd0);

      // starvation: 3 refusals, forced grant, ALU again
      idle();
      bus.issue_ld    = 1'b1;
      bus.issue_ld_rd = 5'd4;
      bus.alu_valid   = 1'b1;
      bus.alu_rd      = 5'd3;
      bus.alu_data    = 32'hAAAA;
      bus.ld_valid    = 1'b1;
      bus.ld_rd       = 5'd4;
      bus.ld_data     = 32'hBBBB;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("stv%0d_ldrdy", i),
             64'(bus.ld_ready), 64'd0);
         chk($sformatf("stv%0d_alurdy", i),
             64'(bus.alu_ready), 64'd1);
         chk($sformatf("stv%0d_rd", i), 64'(bus.rd), 64'd3);
         tick();
         bus.issue_ld = 1'b0;
      end
      chk("stv_cnt", 64'(bus.pending_count), 64'd1);
      #1;
      chk("stv_force_ld", 64'(bus.ld_ready), 64'd1);
      chk("stv_force_alu", 64'(bus.alu_ready), 64'd0);
      chk("stv_force_rd", 64'(bus.rd), 64'd4);
      chk("stv_force_d", 64'(bus.rd_data_in), 64'hBBBB);
      chk("stv_force_we", 64'(bus.rd_write_enable), 64'd1);
      tick();
      chk("stv_cnt_clr", 64'(bus.pending_count), 64'd0);
      #1;
      chk("stv_after_alu", 64'(bus.alu_ready), 64'd1);
      chk("stv_after_ld", 64'(bus.ld_ready), 64'd0);
      chk("stv_after_rd", 64'(bus.rd), 64'd3);
      tick();
      idle();

      // same-cycle issue and grant on x9
      bus.issue_ld    = 1'b1;
      bus.issue_ld_rd = 5'd9;
      tick();
      chk("x9_cnt0", 64'(bus.pending_count), 64'd1);
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd9;
      bus.ld_data  = 32'h99;
      bus.q_rs2    = 5'd9;
      #1;
      chk("x9_ldrdy", 64'(bus.ld_ready), 64'd1);
      tick();
      bus.issue_ld = 1'b0;
      #1;
      chk("x9_cnt1", 64'(bus.pending_count), 64'd1);
      chk("x9_haz", 64'(bus.hazard), 64'd1);
      tick();
      chk("x9_cnt2", 64'(bus.pending_count), 64'd0);
      idle();

      // x0 handling
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd0;
      bus.alu_data  = 32'h55;
      #1;
      chk("x0_alu_rdy", 64'(bus.alu_ready), 64'd1);
      chk("x0_alu_we", 64'(bus.rd_write_enable), 64'd0);
      tick();
      idle();
      bus.ld_valid    = 1'b1;
      bus.ld_rd       = 5'd0;
      bus.ld_data     = 32'h66;
      bus.issue_ld    = 1'b1;
      bus.issue_ld_rd = 5'd0;
      #1;
      chk("x0_ld_rdy", 64'(bus.ld_ready), 64'd1);
      chk("x0_ld_we", 64'(bus.rd_write_enable), 64'd0);
      tick();
      chk("x0_cnt", 64'(bus.pending_count), 64'd0);
      idle();

      // reset in the middle of traffic
      bus.issue_ld    = 1'b1;
      bus.issue_ld_rd = 5'd10;
      tick();
      chk("mid_cnt", 64'(bus.pending_count), 64'd1);
      bus.issue_ld  = 1'b0;
      bus.q_rs1     = 5'd10;
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd12;
      bus.alu_data  = 32'h77;
      bus.ld_valid  = 1'b1;
      bus.ld_rd     = 5'd10;
      bus.ld_data   = 32'h88;
      #1;
      chk("mid_haz", 64'(bus.hazard), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_rst("midrst");
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_cnt", 64'(bus.pending_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
